// File: rtl/phys_pkg.sv
// phys_pkg: shared fixed-point types, model state record and step sequencer states.
package phys_pkg;
    localparam int FRAC_W = 16;
    typedef logic signed [31:0] fx32_t;
    typedef struct packed {
        logic  active;
        fx32_t pos_x, pos_y, pos_z;
        fx32_t vel_x, vel_y, vel_z;
        fx32_t rot_w, rot_x, rot_y, rot_z;
        fx32_t angvel_w, angvel_x, angvel_y, angvel_z;
    } model_state_t;
    localparam int STATE_W = $bits(model_state_t);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_ISSUE, S_WAIT, S_WB, S_NEXT, S_FIN} step_state_t;
endpackage

// File: rtl/physics_step_sched.sv
// physics_step_sched: walks the model table once per step, pushing each active record
// through the shared integrator and writing the result back to its slot.
module physics_step_sched
    import phys_pkg::*;
#(
    parameter int MAX_MODELS = 64,
    parameter int IDX_W = $clog2(MAX_MODELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        dt,
    input  logic [IDX_W:0]     num_models,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [IDX_W-1:0]   mem_addr,
    output logic               mem_rd,
    input  logic [STATE_W-1:0] mem_rdata,
    output logic               mem_wr,
    output logic [STATE_W-1:0] mem_wdata,
    output logic               int_valid,
    input  logic               int_ready,
    output logic [STATE_W-1:0] int_state,
    output logic [31:0]        int_dt,
    input  logic               res_valid,
    input  logic [STATE_W-1:0] res_state,
    output logic               res_ready,
    output logic [IDX_W:0]     models_done
);
    step_state_t state, nxt;
    model_state_t rec, res;
    logic [31:0] dt_q;
    logic [IDX_W:0] num_q;
    logic [IDX_W-1:0] idx;
    logic abort_pend, last;

    assign last = ({1'b0, idx} + 1'b1) == num_q;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = start ? (num_models == '0 ? S_FIN : S_RD) : S_IDLE;
            S_RD:    nxt = S_RDW;
            S_RDW:   nxt = mem_rdata[STATE_W-1] ? S_ISSUE : S_NEXT;
            S_ISSUE: nxt = int_ready ? S_WAIT : S_ISSUE;
            S_WAIT:  nxt = res_valid ? S_WB : S_WAIT;
            S_WB:    nxt = S_NEXT;
            S_NEXT:  nxt = (last || abort_pend || abort) ? S_FIN : S_RD;
            default: nxt = S_IDLE;
        endcase
    end

    // strobes are masked by rst so nothing is issued in the reset cycle
    assign busy      = state != S_IDLE;
    assign done      = state == S_FIN;
    assign aborted   = done && abort_pend;
    assign mem_addr  = idx;
    assign mem_rd    = state == S_RD && !rst;
    assign mem_wr    = state == S_WB && !rst;
    assign mem_wdata = res;
    assign int_valid = state == S_ISSUE && !rst;
    assign int_state = rec;
    assign int_dt    = dt_q;
    assign res_ready = state == S_WAIT && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            models_done <= '0;
            abort_pend  <= 1'b0;
            dt_q        <= '0;
            num_q       <= '0;
            rec         <= '0;
            res         <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && start) begin
                dt_q        <= dt;
                num_q       <= num_models > (IDX_W+1)'(MAX_MODELS) ? (IDX_W+1)'(MAX_MODELS) : num_models;
                idx         <= '0;
                models_done <= '0;
            end
            if (state == S_RDW) rec <= mem_rdata;
            if (state == S_WAIT && res_valid) res <= res_state;
            if (state == S_WB) models_done <= models_done + 1'b1;
            if (state == S_NEXT && nxt == S_RD) idx <= idx + 1'b1;
            abort_pend <= state == S_FIN ? 1'b0 : (state != S_IDLE && abort) ? 1'b1 : abort_pend;
        end
    end
endmodule

// File: tb/tb_physics_step_sched.sv
// tb_physics_step_sched: directed checks of the step sequencer against a behavioural
// state RAM and integrator whose handshake delays can be stretched for one slot.
module tb_physics_step_sched;
    import phys_pkg::*;
    localparam int IDX_W = 6;

    logic clk = 0, rst = 1, start = 0, abort = 0;
    logic [31:0] dt = 0;
    logic [IDX_W:0] num_models = 0;
    logic busy, done, aborted, mem_rd, mem_wr, int_valid, int_ready, res_valid, res_ready;
    logic [IDX_W-1:0] mem_addr;
    logic [STATE_W-1:0] mem_rdata = '0, mem_wdata, int_state, res_state;
    logic [31:0] int_dt;
    logic [IDX_W:0] models_done;

    physics_step_sched dut (
        .clk(clk), .rst(rst), .start(start), .dt(dt), .num_models(num_models), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .int_valid(int_valid),
        .int_ready(int_ready), .int_state(int_state), .int_dt(int_dt), .res_valid(res_valid),
        .res_state(res_state), .res_ready(res_ready), .models_done(models_done)
    );

    always #5 clk = ~clk;

    model_state_t mem [64];
    int checks = 0, errors = 0;
    int slow_slot = -1, rdy_dly = 0, res_dly = 0;
    logic [31:0] cur_dt;

    function automatic model_state_t xf(model_state_t s);
        model_state_t r = s;
        r.pos_x = s.pos_x + s.vel_x;
        r.rot_w = s.rot_w ^ 32'h5a5a_0000;
        return r;
    endfunction

    task automatic check(input string tag, input logic [STATE_W-1:0] got, input logic [STATE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) mem_rdata <= mem_rd ? STATE_W'(mem[mem_addr]) : '0;

    logic [7:0] vcnt, wcnt;
    logic pend;
    model_state_t rres;
    assign int_ready = int_valid && int'(vcnt) >= (int'(mem_addr) == slow_slot ? rdy_dly : 0);
    assign res_valid = pend && int'(wcnt) >= (int'(mem_addr) == slow_slot ? res_dly : 0);
    assign res_state = rres;
    always @(posedge clk) begin
        if (rst) begin
            pend <= 0; vcnt <= 0; wcnt <= 0; rres <= '0;
        end else begin
            if (int_valid && int_ready) begin
                vcnt <= 0; pend <= 1; rres <= xf(int_state);
            end else if (int_valid) vcnt <= vcnt + 1;
            if (res_valid && res_ready) begin
                pend <= 0; wcnt <= 0;
            end else if (pend && res_ready) wcnt <= wcnt + 1;
        end
    end

    int rd_cnt, iv_cnt, hs_cnt, res_cnt, dt_err, stab_err, early_wr, done_cnt;
    int rd_log[$], wr_addr[$];
    logic [STATE_W-1:0] wr_data[$];
    logic prev_stall = 0;
    logic [STATE_W-1:0] prev_st;
    logic [31:0] prev_dt;
    always @(posedge clk) begin
        if (rst) prev_stall = 0;
        if (prev_stall && (!int_valid || int_state !== prev_st || int_dt !== prev_dt)) stab_err++;
        prev_stall = int_valid && !int_ready;
        prev_st = int_state;
        prev_dt = int_dt;
        if (mem_rd) begin rd_cnt++; rd_log.push_back(int'(mem_addr)); end
        if (int_valid) iv_cnt++;
        if (int_valid && int_ready) begin hs_cnt++; if (int_dt !== cur_dt) dt_err++; end
        if (res_valid && res_ready) res_cnt++;
        if (mem_wr) begin
            if (res_cnt <= wr_addr.size()) early_wr++;
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic clr();
        rd_cnt = 0; iv_cnt = 0; hs_cnt = 0; res_cnt = 0; dt_err = 0; stab_err = 0; early_wr = 0; done_cnt = 0;
        rd_log.delete(); wr_addr.delete(); wr_data.delete();
    endtask

    task automatic start_step(input int n, input logic [31:0] d);
        clr();
        cur_dt = d;
        @(negedge clk);
        start = 1; num_models = n[IDX_W:0]; dt = d;
        @(negedge clk);
        start = 0;
    endtask

    int lat, md;
    logic ab;
    task automatic wait_done();
        lat = 1;
        while (!done && lat < 3000) begin @(negedge clk); lat++; end
        if (!done) check("done_timeout", 0, 1);
        ab = aborted; md = int'(models_done);
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int exp_addr[$]);
        check({tag, "_wr_cnt"}, wr_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            check({tag, "_wr_addr"}, wr_addr[i], exp_addr[i]);
            check({tag, "_wr_data"}, wr_data[i], xf(mem[exp_addr[i]]));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            mem[i].active = 1;
            mem[i].pos_x = 32'h0001_0000 * i;
            mem[i].vel_x = 32'h0000_8000 + i;
            mem[i].rot_w = 32'h0001_0000;
            mem[i].angvel_z = 32'h100 + i;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_models_done", models_done, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_int_valid", int_valid, 0);
        rst = 0;

        start_step(3, 32'h0000_8000);
        wait_done();
        check("basic_latency", lat, 19);
        check("basic_done_pulses", done_cnt, 1);
        check("basic_models_done", md, 3);
        check("basic_aborted", ab, 0);
        check("basic_handshakes", hs_cnt, 3);
        check("basic_dt", dt_err, 0);
        check_writes("basic", '{0, 1, 2});

        start_step(0, 32'h0001_0000);
        wait_done();
        check("zero_latency_le2", lat <= 2, 1);
        check("zero_done_pulses", done_cnt, 1);
        check("zero_rd", rd_cnt, 0);
        check("zero_int_valid", iv_cnt, 0);
        check("zero_wr", wr_addr.size(), 0);

        slow_slot = 1; rdy_dly = 5; res_dly = 7;
        start_step(3, 32'h0002_4000);
        wait_done();
        check("stall_latency", lat, 31);
        check("stall_stable", stab_err, 0);
        check("stall_handshakes", hs_cnt, 3);
        check("stall_early_wr", early_wr, 0);
        check("stall_dt", dt_err, 0);
        check_writes("stall", '{0, 1, 2});
        slow_slot = -1;

        mem[2].active = 0;
        start_step(4, 32'h0000_4000);
        wait_done();
        check("skip_latency", lat, 22);
        check("skip_models_done", md, 3);
        check("skip_handshakes", hs_cnt, 3);
        check_writes("skip", '{0, 1, 3});
        mem[2].active = 1;

        slow_slot = 1; res_dly = 3;
        start_step(5, 32'h0000_8000);
        for (int n = 0; !(res_ready && mem_addr == 1) && n < 200; n++) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        wait_done();
        check("abort_flag", ab, 1);
        check("abort_models_done", md, 2);
        check("abort_reads", rd_cnt, 2);
        check_writes("abort", '{0, 1});
        slow_slot = -1;

        start_step(2, 32'h0000_8000);
        wait_done();
        check("post_abort_flag", ab, 0);
        check("post_abort_models_done", md, 2);

        slow_slot = 2; rdy_dly = 5;
        start_step(3, 32'h0000_8000);
        for (int n = 0; !(int_valid && mem_addr == 2) && n < 200; n++) @(negedge clk);
        check("rstmid_in_issue", int_valid && mem_addr == 2, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rstmid_busy", busy, 0);
        check("rstmid_int_valid", int_valid, 0);
        repeat (3) @(negedge clk);
        check("rstmid_writes", wr_addr.size(), 2);
        check("rstmid_no_done", done_cnt, 0);
        slow_slot = -1;
        start_step(3, 32'h0000_8000);
        wait_done();
        check("restart_first_read", rd_log.size() > 0 ? rd_log[0] : -1, 0);
        check("restart_models_done", md, 3);
        check_writes("restart", '{0, 1, 2});

        start_step(127, 32'h0000_1000);
        wait_done();
        check("clamp_models_done", md, 64);
        check("clamp_latency", lat, 385);
        check("clamp_writes", wr_addr.size(), 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
